// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - request/status bundle between the reset sequencer and its users
//
// Purpose: groups the reset-request inputs and the staged-reset status outputs.
// Signals:
//   sw_rst_req  software reset request, sampled per cycle
//   wdt_en      watchdog enable level
//   wdt_kick    watchdog service pulse
//   rst_out_n   staged active-low resets, bit 0 released first
//   busy        high while any rst_out_n bit is asserted
//   rst_cause   cause of last reset: 00 supervisor, 01 software, 10 watchdog
// Modports: master drives requests and observes status; slave is the sequencer.
interface rst_seq_if #(
  parameter int NOUT = 3
);
  logic            sw_rst_req;
  logic            wdt_en;
  logic            wdt_kick;
  logic [NOUT-1:0] rst_out_n;
  logic            busy;
  logic [1:0]      rst_cause;

  modport master (
    output sw_rst_req, wdt_en, wdt_kick,
    input  rst_out_n, busy, rst_cause
  );

  modport slave (
    input  sw_rst_req, wdt_en, wdt_kick,
    output rst_out_n, busy, rst_cause
  );
endinterface

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset sequencer with software and watchdog reset
//
// Purpose: takes the supervisor's open-drain reset as an asynchronous
// active-low reset, synchronizes its release, then releases NOUT reset
// domains in order, STAGE_DLY cycles apart. In RUN, a software request or
// watchdog timeout holds all domains for HOLD_CYC cycles and replays the
// staged release, recording the cause.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low supervisor reset
//   bus    rst_seq_if.slave (requests in, staged resets/busy/cause out)
module rst_seq #(
  parameter int NOUT        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STAGE_DLY   = 16,
  parameter int HOLD_CYC    = 32,
  parameter int WDT_TO      = 1000
) (
  input  logic     clk,
  input  logic     rst_n,
  rst_seq_if.slave bus
);

  localparam int SW = $clog2(STAGE_DLY + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;

  localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_DLY - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NOUT - 1);
  localparam logic [31:0]   WDT_LAST  = 32'(WDT_TO - 1);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_REL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [SW-1:0]          stg_cnt_q, stg_cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [31:0]            wdt_cnt_q, wdt_cnt_d;
  logic [NOUT-1:0]        rst_out_q, rst_out_d;
  logic [1:0]             cause_q, cause_d;
  logic                   wdt_fire;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d    = state_q;
    stg_cnt_d  = stg_cnt_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    wdt_cnt_d  = '0;
    rst_out_d  = rst_out_q;
    cause_d    = cause_q;
    wdt_fire   = 1'b0;

    case (state_q)
      ST_SYNC: begin
        stg_cnt_d = '0;
        idx_d     = '0;
        // Leave on the edge the synchronizer output rises so stage 0
        // releases STAGE_DLY edges after that point.
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = ST_REL;
        end
      end

      ST_REL: begin
        if (stg_cnt_q == STG_LAST) begin
          rst_out_d[idx_q] = 1'b1;
          stg_cnt_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          stg_cnt_d = stg_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (!bus.wdt_en || bus.wdt_kick) begin
          wdt_cnt_d = '0;
        end else if (wdt_cnt_q == WDT_LAST) begin
          wdt_fire  = 1'b1;
          wdt_cnt_d = wdt_cnt_q;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 32'd1;
        end

        if (bus.sw_rst_req || wdt_fire) begin
          state_d    = ST_HOLD;
          rst_out_d  = '0;
          hold_cnt_d = '0;
          wdt_cnt_d  = '0;
          cause_d    = bus.sw_rst_req ? CAUSE_SW : CAUSE_WDT;
        end
      end

      default: begin  // ST_HOLD
        rst_out_d = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_REL;
          stg_cnt_d  = '0;
          idx_d      = '0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_SYNC;
      stg_cnt_q  <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      wdt_cnt_q  <= '0;
      rst_out_q  <= '0;
      cause_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      stg_cnt_q  <= stg_cnt_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      wdt_cnt_q  <= wdt_cnt_d;
      rst_out_q  <= rst_out_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.rst_out_n = rst_out_q;
  assign bus.busy      = ~&rst_out_q;
  assign bus.rst_cause = cause_q;

endmodule
